instr_fetch_queue: RTL and testbench

In-order instruction fetch stage sitting directly upstream of the core datapath: it generates sequential PCs, issues requests to instruction memory, buffers returning instruction words with their PCs in a small FIFO, and hands them to decode and datapath over a valid/ready handshake. A redirect (taken branch or jump resolved downstream) flushes the queue, discards in-flight responses, and restarts fetch at the new target.

---
 rtl/instr_fetch_queue_pkg.sv | 17 +
 rtl/instr_fetch_queue_if.sv | 29 ++
 rtl/instr_fetch_queue_fifo.sv | 50 +++++
 rtl/instr_fetch_queue.sv | 111 +++++++++++
 tb/tb_instr_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch types and constants: instruction/PC width, NOP encoding, PC step, queue entry layout.
package fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch stage bus bundle: imem request/response, redirect, decode-side valid/ready, busy.
interface instr_fetch_queue_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pcplus4;
    logic            busy;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4, busy,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pcplus4, busy,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO, flush wins over push/pop; pop data is the head, visible the
// cycle after push. No full flag: the caller's credit scheme guarantees no push while full.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign pop_dat = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign empty   = (r_count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order fetch: sequential imem requests throttled by queue+outstanding credits, responses queued with PCs,
// head to decode over valid/ready; redirect flushes and drops in-flight data. INSTR_FETCH_BYPASS_EN: empty-queue bypass.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_queue_if.master bus
);
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_stale;

    logic [CW-1:0]   w_occ;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW:0]     w_credits;
    logic            w_req;
    logic            w_empty;
    logic            w_grant;
    logic            w_resp_live;
    logic            w_push;
    logic            w_pop;
    logic            w_out_vld;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head;
    fetch_entry_t    w_out_ent;

    // Credits count both queued entries and requests still in flight, so a push can never find the queue full.
    assign w_credits = {1'b0, w_occ} + {1'b0, r_outstanding};
    assign w_req     = reset & (w_credits < LP_DEPTH);
    assign w_grant   = w_req & bus.imem_gnt;

    assign w_outstanding_nxt = r_outstanding + CW'(w_grant) - CW'(bus.imem_rvalid);
    assign w_redirect_pc     = align_pc(bus.redirect_pc);

    assign w_resp_live = bus.imem_rvalid & (r_stale == '0) & ~bus.redirect_valid;
    assign w_push_ent  = '{instr: bus.imem_rdata, pc: r_resp_pc};
    assign w_pop       = ~w_empty & bus.out_ready;

`ifdef INSTR_FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_resp_live & w_empty;
    assign w_push    = w_resp_live & ~(w_bypass & bus.out_ready);
    assign w_out_vld = ~w_empty | w_bypass;
    assign w_out_ent = w_empty ? w_push_ent : w_head;
`else
    assign w_push    = w_resp_live;
    assign w_out_vld = ~w_empty;
    assign w_out_ent = w_head;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (bus.redirect_valid),
        .push     (w_push),
        .push_dat (w_push_ent),
        .pop      (w_pop),
        .pop_dat  (w_head),
        .count    (w_occ),
        .empty    (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_stale    <= w_outstanding_nxt;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (bus.imem_rvalid) begin
                    if (r_stale != '0) begin
                        r_stale <= r_stale - CW'(1);
                    end else begin
                        r_resp_pc <= r_resp_pc + PC_STEP;
                    end
                end
            end
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.out_valid   = w_out_vld;
    assign bus.out_instr   = w_out_vld ? w_out_ent.instr : NOP_INSTR;
    assign bus.out_pc      = w_out_vld ? w_out_ent.pc : '0;
    assign bus.out_pcplus4 = bus.out_pc + PC_STEP;
    assign bus.busy        = (r_outstanding != '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed + random bench for instr_fetch_queue with an in-bench memory and a queue-level reference model.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int k_lat = 1, k_gnt_pct = 100, k_ready = 1, k_redir_pct = 0;

    req_t        pend[$];
    ent_t        q[$];
    logic [31:0] fetch_pc = RESET_PC;
    logic [31:0] acc_pc[$];
    logic [31:0] acc_p4[$];
    bit          s_req, s_gnt, s_rv, s_rdy, s_redir, s_byp;
    logic [31:0] s_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        pend.delete();
        q.delete();
        fetch_pc = RESET_PC;
    endtask

    task automatic sample_and_check();
        bit   v;
        ent_t h;
        v     = 1'b0;
        h     = '{32'h0, NOP};
        s_byp = 1'b0;
        if (q.size() > 0) begin
            v = 1'b1;
            h = q[0];
        end
`ifdef INSTR_FETCH_BYPASS_EN
        else if (rst_n && bus.imem_rvalid && pend.size() > 0 && !pend[0].stale && !bus.redirect_valid) begin
            v     = 1'b1;
            s_byp = 1'b1;
            h     = '{pend[0].addr, mem_word(pend[0].addr)};
        end
`endif
        chk("out_valid",   bus.out_valid,   v);
        chk("out_pc",      bus.out_pc,      v ? h.pc : 32'h0);
        chk("out_instr",   bus.out_instr,   v ? h.instr : NOP);
        chk("out_pcplus4", bus.out_pcplus4, (v ? h.pc : 32'h0) + 32'd4);
        chk("imem_req",    bus.imem_req,    rst_n && (q.size() + pend.size() < DEPTH));
        chk("imem_addr",   bus.imem_addr,   fetch_pc);
        chk("busy",        bus.busy,        pend.size() != 0);
        s_req   = bus.imem_req;
        s_gnt   = bus.imem_gnt;
        s_rv    = bus.imem_rvalid;
        s_rdy   = bus.out_ready;
        s_redir = bus.redirect_valid;
        s_rpc   = bus.redirect_pc;
        if (bus.out_valid && bus.out_ready) begin
            acc_pc.push_back(bus.out_pc);
            acc_p4.push_back(bus.out_pcplus4);
        end
    endtask

    task automatic update_model();
        req_t r;
        if (!rst_n) begin
            reset_model();
            cyc++;
            return;
        end
        if (s_rdy && q.size() > 0) q.delete(0);
        if (s_rv && pend.size() > 0) begin
            r = pend.pop_front();
            if (!r.stale && !s_redir && !(s_byp && s_rdy)) q.push_back('{r.addr, mem_word(r.addr)});
        end
        if (s_req && s_gnt) begin
            r.addr  = fetch_pc;
            r.stale = 1'b0;
            r.due   = cyc + ((k_lat == 0) ? int'($urandom_range(4, 1)) : k_lat);
            pend.push_back(r);
            fetch_pc = fetch_pc + 32'd4;
        end
        if (s_redir) begin
            q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            fetch_pc = {s_rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic drive_next();
        bus.imem_gnt       = ($urandom_range(99) < k_gnt_pct);
        bus.out_ready      = (k_ready == 2) ? 1'($urandom_range(1)) : (k_ready == 1);
        bus.redirect_valid = ($urandom_range(99) < k_redir_pct);
        bus.redirect_pc    = $urandom();
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_and_check();
        @(posedge clk);
        update_model();
        #1;
        drive_next();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, bus.out_valid, 1'b1);
    endtask

    initial begin
        int n;
        int n0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // Reset values, then first request at RESET_PC.
        tick_n(3);
        rst_n = 1'b1;
        #1;
        chk("rel_req",  bus.imem_req,  1'b1);
        chk("rel_addr", bus.imem_addr, RESET_PC);

        // Streaming: single-cycle memory, always ready.
        tick_n(10);
        n0 = acc_pc.size();
        tick_n(10);
        chk("throughput", acc_pc.size() - n0, 10);

        // Consumer stall: queue fills, requests stop, nothing lost.
        k_ready = 0; bus.out_ready = 1'b0;
        tick_n(10);
        chk("stall_req",   bus.imem_req,  1'b0);
        chk("stall_busy",  bus.busy,      1'b0);
        chk("stall_valid", bus.out_valid, 1'b1);
        k_ready = 1; bus.out_ready = 1'b1;
        tick_n(12);

        // Redirect with two requests outstanding at 3-cycle latency.
        k_lat = 3;
        tick_n(8);
        k_gnt_pct = 0; bus.imem_gnt = 1'b0;
        tick_n(8);
        k_gnt_pct = 100; bus.imem_gnt = 1'b1;
        tick_n(2);
        chk("pre_redir_busy", bus.busy, 1'b1);
        bus.imem_gnt = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
        tick();
        chk("redir_valid0", bus.out_valid, 1'b0);
        chk("redir_req",    bus.imem_req,  1'b1);
        chk("redir_addr",   bus.imem_addr, 32'h0000_0100);
        wait_valid("redir");
        chk("redir_pc", bus.out_pc, 32'h0000_0100);

        // Redirect coinciding with a grant and a response.
        k_lat = 1;
        tick_n(6);
        chk("sc_pre_req", bus.imem_req, 1'b1);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
        tick();
        chk("sc_addr",  bus.imem_addr, 32'h0000_0200);
        chk("sc_busy",  bus.busy,      1'b1);
        chk("sc_valid", bus.out_valid, 1'b0);
        wait_valid("sc");
        chk("sc_pc", bus.out_pc, 32'h0000_0200);

        // PC wrap; low redirect bits ignored.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF9;
        tick();
        acc_pc.delete(); acc_p4.delete();
        n = 0;
        while (acc_pc.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        chk("wrap_count", acc_pc.size() >= 3, 1'b1);
        if (acc_pc.size() >= 3) begin
            chk("wrap_pc0", acc_pc[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", acc_pc[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", acc_pc[2], 32'h0000_0000);
            chk("wrap_p4",  acc_p4[2], 32'h0000_0004);
        end

        // Reset mid-stream with three queued entries.
        k_ready = 0; bus.out_ready = 1'b0;
        n = 0;
        while (q.size() != 3 && n < 40) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        reset_model();
        bus.imem_rvalid = 1'b0;
        #1;
        chk("mr_valid", bus.out_valid, 1'b0);
        chk("mr_instr", bus.out_instr, NOP);
        chk("mr_pc",    bus.out_pc,    32'h0);
        chk("mr_req",   bus.imem_req,  1'b0);
        chk("mr_busy",  bus.busy,      1'b0);
        tick_n(2);
        rst_n = 1'b1; k_ready = 1; bus.out_ready = 1'b1;
        #1;
        chk("mr_rel_req",  bus.imem_req,  1'b1);
        chk("mr_rel_addr", bus.imem_addr, RESET_PC);
        tick_n(10);

        // Random grants, latencies, backpressure and redirects.
        k_lat = 0; k_gnt_pct = 70; k_ready = 2; k_redir_pct = 3;
        tick_n(500);
        k_redir_pct = 0; k_ready = 1;
        tick_n(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
